fifo_wptr_full: RTL and testbench

Write-side pointer and full-flag generator for the asynchronous FIFO. Lives entirely in the write clock domain: accepts write requests, produces the RAM write address and enable, and drives the Gray-coded write pointer that the two-stage synchronizer carries into the read domain. Computes `full` against the read pointer after that pointer has been synchronized into this domain.

---
 rtl/fifo_wptr_full.sv | 62 ++++++
 tb/tb_fifo_wptr_full.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer/full generator for the async FIFO: binary + Gray write pointer,
// registered full flag, write-side level. Optional almost_full under FIFO_ALMOST_FULL_EN.
module fifo_wptr_full #(
   parameter int ADDR      = 4,
   parameter int AF_MARGIN = 2
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            write_en,
   input  logic [ADDR:0]   rptr_sync,
   output logic            write_accept,
   output logic [ADDR-1:0] waddr,
   output logic [ADDR:0]   wptr,
   output logic            full,
`ifdef FIFO_ALMOST_FULL_EN
   output logic            almost_full,
`endif
   output logic [ADDR:0]   wlevel
);

   localparam int DEPTH = 2**ADDR;

   logic [ADDR:0] wbin, wbin_next, wgray_next, rbin, wfull_cmp;

   assign write_accept = write_en & ~full;
   assign wbin_next    = wbin + {{ADDR{1'b0}}, write_accept};
   assign wgray_next   = (wbin_next >> 1) ^ wbin_next;
   assign waddr        = wbin[ADDR-1:0];

   // Gray->binary: each bit is the XOR of itself and every bit above it.
   for (genvar i = 0; i <= ADDR; i++) begin : g_g2b
      assign rbin[i] = ^rptr_sync[ADDR:i];
   end

   // Full when pointers match except for the two wrap-distinguishing MSBs.
   assign wfull_cmp = {~rptr_sync[ADDR:ADDR-1], rptr_sync[ADDR-2:0]};
   assign wlevel    = wbin - rbin;

`ifdef FIFO_ALMOST_FULL_EN
   localparam logic [ADDR:0] AF_THRESH = (ADDR+1)'(DEPTH - AF_MARGIN);
   logic [ADDR:0] wlevel_next;
   assign wlevel_next = wbin_next - rbin;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) almost_full <= 1'b0;
      else          almost_full <= (wlevel_next >= AF_THRESH);
   end
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wbin <= '0;
         wptr <= '0;
         full <= 1'b0;
      end else begin
         wbin <= wbin_next;
         wptr <= wgray_next;
         full <= (wgray_next == wfull_cmp);
      end
   end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full (ADDR=4): reset, fill/full/release table, Gray
// stepping with a lagging reader, async reset mid-fill, and almost_full when compiled in.
module tb_fifo_wptr_full;

   localparam int ADDR = 4;

   logic            clock = 1'b0;
   logic            reset_n;
   logic            write_en;
   logic [ADDR:0]   rptr_sync;
   logic            write_accept;
   logic [ADDR-1:0] waddr;
   logic [ADDR:0]   wptr;
   logic            full;
   logic [ADDR:0]   wlevel;
`ifdef FIFO_ALMOST_FULL_EN
   logic            almost_full;
`endif

   int checks = 0;
   int errors = 0;

   fifo_wptr_full #(.ADDR(ADDR), .AF_MARGIN(2)) dut (
      .clock(clock), .reset_n(reset_n), .write_en(write_en), .rptr_sync(rptr_sync),
      .write_accept(write_accept), .waddr(waddr), .wptr(wptr), .full(full),
`ifdef FIFO_ALMOST_FULL_EN
      .almost_full(almost_full),
`endif
      .wlevel(wlevel));

   always #5 clock = ~clock;

   typedef struct {
      logic       we;
      logic [4:0] rptr;
      logic       acc;    // expected write_accept before the edge
      logic [3:0] waddr;  // expected after the edge
      logic [4:0] wptr;
      logic       full;
      logic [4:0] wlevel;
   } vec_t;

   vec_t tv[19];

   function automatic logic [4:0] gray(input int b);
      logic [4:0] v;
      v = 5'(b);
      return (v >> 1) ^ v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0; write_en = 1'b0; rptr_sync = '0;
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic edge_settle();
      @(posedge clock);
      #1;
   endtask

   initial begin
      int wcnt, rcnt;
      logic [4:0] prev;
      bit wrapped;

      // Fill table: 16 writes, a blocked 17th, release via rptr=Gray(1), then refill.
      for (int i = 0; i < 16; i++)
         tv[i] = '{1'b1, 5'd0, 1'b1, 4'((i + 1) % 16), gray(i + 1), (i == 15), 5'(i + 1)};
      tv[16] = '{1'b1, 5'd0,      1'b0, 4'd0, 5'b11000, 1'b1, 5'd16};
      tv[17] = '{1'b0, 5'b00001,  1'b0, 4'd0, 5'b11000, 1'b0, 5'd15};
      tv[18] = '{1'b1, 5'b00001,  1'b1, 4'd1, 5'b11001, 1'b1, 5'd16};

      // Reset held with write_en high: no edge may advance state.
      reset_n = 1'b0; write_en = 1'b1; rptr_sync = '0;
      edge_settle();
      edge_settle();
      chk("rst_waddr", 32'(waddr), 0);
      chk("rst_wptr", 32'(wptr), 0);
      chk("rst_wlevel", 32'(wlevel), 0);
      chk("rst_full", 32'(full), 0);
      @(negedge clock);
      reset_n = 1'b1;
      edge_settle();
      chk("rel_waddr", 32'(waddr), 1);
      chk("rel_wptr", 32'(wptr), 32'(gray(1)));

      do_reset();
      for (int i = 0; i < 19; i++) begin
         @(negedge clock);
         write_en = tv[i].we; rptr_sync = tv[i].rptr;
         #1;
         chk($sformatf("v%0d_accept", i), 32'(write_accept), 32'(tv[i].acc));
         edge_settle();
         chk($sformatf("v%0d_waddr", i), 32'(waddr), 32'(tv[i].waddr));
         chk($sformatf("v%0d_wptr", i), 32'(wptr), 32'(tv[i].wptr));
         chk($sformatf("v%0d_full", i), 32'(full), 32'(tv[i].full));
         chk($sformatf("v%0d_wlevel", i), 32'(wlevel), 32'(tv[i].wlevel));
      end

      // 40 writes with a reader trailing two writes behind.
      do_reset();
      wcnt = 0; wrapped = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         rcnt = (wcnt >= 2) ? wcnt - 2 : 0;
         rptr_sync = gray(rcnt % 32);
         write_en = 1'b1;
         prev = wptr;
         edge_settle();
         wcnt++;
         if (waddr == 4'd0 && wcnt == 16) wrapped = 1;
         chk($sformatf("g%0d_hamming", i), 32'($countones(prev ^ wptr)), 1);
         chk($sformatf("g%0d_waddr", i), 32'(waddr), 32'(wcnt % 16));
         chk($sformatf("g%0d_wptr", i), 32'(wptr), 32'(gray(wcnt % 32)));
         chk($sformatf("g%0d_wlevel", i), 32'(wlevel), 32'(wcnt - rcnt));
         chk($sformatf("g%0d_full", i), 32'(full), 0);
      end
      chk("gray_wrap_seen", 32'(wrapped), 1);

      // Async reset between edges at level 9.
      do_reset();
      for (int i = 0; i < 9; i++) begin
         @(negedge clock);
         write_en = 1'b1;
         edge_settle();
      end
      chk("mid_wlevel9", 32'(wlevel), 9);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_waddr", 32'(waddr), 0);
      chk("async_wptr", 32'(wptr), 0);
      chk("async_wlevel", 32'(wlevel), 0);
      chk("async_full", 32'(full), 0);
`ifdef FIFO_ALMOST_FULL_EN
      chk("async_af", 32'(almost_full), 0);
`endif

`ifdef FIFO_ALMOST_FULL_EN
      do_reset();
      for (int i = 0; i < 14; i++) begin
         @(negedge clock);
         write_en = 1'b1; rptr_sync = '0;
         edge_settle();
         chk($sformatf("af_w%0d", i + 1), 32'(almost_full), 32'(i == 13));
      end
      chk("af_full14", 32'(full), 0);
      @(negedge clock);
      write_en = 1'b0; rptr_sync = 5'b00001;
      edge_settle();
      chk("af_clear_level", 32'(wlevel), 13);
      chk("af_clear", 32'(almost_full), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
